// File: rtl/dec_stream_loader.sv
// dec_stream_loader
//   Host-side front end of the DEC decision-tree accelerator. Takes a flat
//   byte stream over a valid/ready link. The stream holds the tree parameters
//   (feature indices, thresholds, children), followed by sample features.
//   The block re-packs the stream into DEC's parallel load words: mode,
//   address, eight feature lanes and a sample ID.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, skip_params   start a run (IDLE/DONE only); skip_params jumps to samples
//   s_valid/s_data/s_ready   byte stream input
//   dec_ready            DEC input_ready
//   dec_valid, dec_mode, dec_data_0..7, dec_id   load word towards DEC
//   busy, done           run status
module dec_stream_loader #(
   parameter int NUM_FEATURE = 8,
   parameter int NUM_NODE    = 11,
   parameter int NUM_DATA    = 2874,
   parameter int ID_W        = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            skip_params,
   input  logic            s_valid,
   input  logic [7:0]      s_data,
   output logic            s_ready,
   input  logic            dec_ready,
   output logic            dec_valid,
   output logic [1:0]      dec_mode,
   output logic [7:0]      dec_data_0,
   output logic [7:0]      dec_data_1,
   output logic [7:0]      dec_data_2,
   output logic [7:0]      dec_data_3,
   output logic [7:0]      dec_data_4,
   output logic [7:0]      dec_data_5,
   output logic [7:0]      dec_data_6,
   output logic [7:0]      dec_data_7,
   output logic [ID_W-1:0] dec_id,
   output logic            busy,
   output logic            done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LD_FEA, ST_LD_THD, ST_LD_CHILD, ST_LD_DATA, ST_DRAIN, ST_DONE
   } state_t;

   localparam logic [8:0]      LAST_NODE   = 9'(NUM_NODE - 1);
   localparam logic [8:0]      LAST_CHILD  = 9'(2 * NUM_NODE - 1);
   localparam logic [2:0]      LAST_BYTE   = 3'(NUM_FEATURE - 1);
   localparam logic [ID_W-1:0] LAST_SAMPLE = ID_W'(NUM_DATA - 1);
   localparam logic [ID_W-1:0] ONE_ID      = ID_W'(1);

   state_t          state_reg, state_next;
   logic [8:0]      idx_reg;
   logic [2:0]      byte_cnt_reg;
   logic [ID_W-1:0] sample_cnt_reg;
   logic [7:0]      gather_reg [0:NUM_FEATURE-2];
   logic [7:0]      lane_reg   [0:NUM_FEATURE-1];
   logic            valid_reg;
   logic [1:0]      mode_reg;
   logic [ID_W-1:0] id_reg;

   logic in_param, out_free, accept, xfer, start_ok;
   logic load_param, load_data, gather_wr, idx_wrap;
   logic [1:0] param_mode;

   assign in_param   = (state_reg == ST_LD_FEA) || (state_reg == ST_LD_THD) ||
                       (state_reg == ST_LD_CHILD);
   // Single-entry output register: free when empty or emptying this edge.
   assign out_free   = !valid_reg || dec_ready;
   assign accept     = s_valid && s_ready;
   assign xfer       = valid_reg && dec_ready;
   assign start_ok   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign load_param = accept && in_param;
   assign gather_wr  = accept && (state_reg == ST_LD_DATA);
   // The last feature byte of a sample completes the word.
   assign load_data  = gather_wr && (byte_cnt_reg == LAST_BYTE);
   assign idx_wrap   = idx_reg == ((state_reg == ST_LD_CHILD) ? LAST_CHILD : LAST_NODE);
   assign param_mode = (state_reg == ST_LD_FEA) ? 2'b00 :
                       (state_reg == ST_LD_THD) ? 2'b01 : 2'b10;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE:
            if (start) state_next = skip_params ? ST_LD_DATA : ST_LD_FEA;
         ST_LD_FEA:   if (load_param && idx_wrap) state_next = ST_LD_THD;
         ST_LD_THD:   if (load_param && idx_wrap) state_next = ST_LD_CHILD;
         ST_LD_CHILD: if (load_param && idx_wrap) state_next = ST_LD_DATA;
         ST_LD_DATA:  if (load_data && (sample_cnt_reg == LAST_SAMPLE)) state_next = ST_DRAIN;
         ST_DRAIN:    if (xfer) state_next = ST_DONE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_reg)
         ST_IDLE:  busy = 1'b0;
         ST_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         ST_LD_FEA, ST_LD_THD, ST_LD_CHILD: s_ready = out_free;
         // Only the completing byte needs the output register.
         ST_LD_DATA: s_ready = (byte_cnt_reg != LAST_BYTE) || out_free;
         ST_DRAIN:   s_ready = 1'b0;
         default:    busy = 1'b0;
      endcase
   end

   // Counters, gather buffer and output word register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg        <= '0;
         byte_cnt_reg   <= '0;
         sample_cnt_reg <= '0;
         valid_reg      <= 1'b0;
         mode_reg       <= '0;
         id_reg         <= '0;
         for (int i = 0; i < NUM_FEATURE - 1; i++) gather_reg[i] <= '0;
         for (int i = 0; i < NUM_FEATURE; i++)     lane_reg[i]   <= '0;
      end else begin
         if (start_ok) begin
            idx_reg        <= '0;
            byte_cnt_reg   <= '0;
            sample_cnt_reg <= '0;
         end else begin
            if (load_param) idx_reg <= idx_wrap ? 9'd0 : idx_reg + 9'd1;
            if (gather_wr)  byte_cnt_reg <= (byte_cnt_reg == LAST_BYTE) ? 3'd0 : byte_cnt_reg + 3'd1;
            if (load_data)  sample_cnt_reg <= sample_cnt_reg + ONE_ID;
         end

         for (int i = 0; i < NUM_FEATURE - 1; i++)
            if (gather_wr && (byte_cnt_reg == 3'(i))) gather_reg[i] <= s_data;

         if (load_param || load_data) valid_reg <= 1'b1;
         else if (xfer)               valid_reg <= 1'b0;

         if (load_param) begin
            mode_reg    <= param_mode;
            lane_reg[0] <= s_data;
            lane_reg[1] <= idx_reg[7:0];
            lane_reg[2] <= (state_reg == ST_LD_CHILD) ? {7'b0, idx_reg[8]} : 8'd0;
            for (int i = 3; i < NUM_FEATURE; i++) lane_reg[i] <= '0;
            id_reg      <= '0;
         end else if (load_data) begin
            mode_reg <= 2'b11;
            for (int i = 0; i < NUM_FEATURE - 1; i++) lane_reg[i] <= gather_reg[i];
            lane_reg[NUM_FEATURE-1] <= s_data;
            id_reg   <= sample_cnt_reg + ONE_ID;
         end
      end
   end

   assign dec_valid  = valid_reg;
   assign dec_mode   = mode_reg;
   assign dec_id     = id_reg;
   assign dec_data_0 = lane_reg[0];
   assign dec_data_1 = lane_reg[1];
   assign dec_data_2 = lane_reg[2];
   assign dec_data_3 = lane_reg[3];
   assign dec_data_4 = lane_reg[4];
   assign dec_data_5 = lane_reg[5];
   assign dec_data_6 = lane_reg[6];
   assign dec_data_7 = lane_reg[7];

endmodule
